// File: rtl/bus_arbiter_rr.sv
// bus_arbiter_rr: round-robin N-master bus arbiter with serial slave-address capture.
// Defining ARB_TIMEOUT_EN bounds each tenure to TIMEOUT_CYCLES and pulses timeout_err on forced release.
module bus_arbiter_rr #(
    parameter int NUM_MASTERS    = 4,
    parameter int SLAVE_SEL_W    = 2,
    parameter int MASTER_ID_W    = $clog2(NUM_MASTERS + 1),
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_MASTERS-1:0] m_request,
    input  logic [NUM_MASTERS-1:0] m_slave_select,
    output logic [NUM_MASTERS-1:0] m_grant,
    output logic [MASTER_ID_W-1:0] bus_grant,
    output logic [SLAVE_SEL_W-1:0] slave_grant,
    output logic                   slave_valid,
    output logic                   busy,
    output logic                   timeout_err
);
    localparam int IDX_W = $clog2(NUM_MASTERS);
    localparam int CNT_W = $clog2(SLAVE_SEL_W + 1);
    typedef enum logic [1:0] {IDLE, ADDR, OCCUPIED} state_t;
    state_t           state;
    logic [IDX_W-1:0] rr_last, pick;
    logic [CNT_W-1:0] cnt;
    logic             owner_req, sel_bit, release_now;
    assign owner_req = m_request[rr_last];
    assign sel_bit   = m_slave_select[rr_last];
    // rr_last doubles as the owner index for the whole tenure
    always_comb begin
        pick = rr_last;
        for (int i = NUM_MASTERS; i >= 1; i--)
            if (m_request[(int'(rr_last) + i) % NUM_MASTERS])
                pick = IDX_W'((int'(rr_last) + i) % NUM_MASTERS);
    end
`ifdef ARB_TIMEOUT_EN
    localparam int HOLD_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [HOLD_W-1:0] hold;
    assign release_now = state != IDLE &&
                         (!owner_req || (state == OCCUPIED && hold == HOLD_W'(TIMEOUT_CYCLES - 1)));
`else
    assign release_now = state != IDLE && !owner_req;
    assign timeout_err = 1'b0;
`endif
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            m_grant     <= '0;
            bus_grant   <= '0;
            slave_grant <= '0;
            slave_valid <= 1'b0;
            busy        <= 1'b0;
            rr_last     <= IDX_W'(NUM_MASTERS - 1);
            cnt         <= '0;
`ifdef ARB_TIMEOUT_EN
            hold        <= '0;
            timeout_err <= 1'b0;
`endif
        end else begin
`ifdef ARB_TIMEOUT_EN
            timeout_err <= 1'b0;
`endif
            if (state == IDLE) begin
                if (|m_request) begin
                    state       <= ADDR;
                    m_grant     <= NUM_MASTERS'(1) << pick;
                    bus_grant   <= MASTER_ID_W'(pick) + MASTER_ID_W'(1);
                    busy        <= 1'b1;
                    rr_last     <= pick;
                    cnt         <= '0;
                    slave_grant <= '0;
                end
            end else if (release_now) begin
                state       <= IDLE;
                m_grant     <= '0;
                bus_grant   <= '0;
                busy        <= 1'b0;
                slave_valid <= 1'b0;
                cnt         <= '0;
`ifdef ARB_TIMEOUT_EN
                timeout_err <= owner_req;
`endif
            end else if (state == ADDR) begin
                slave_grant <= slave_grant | (SLAVE_SEL_W'(sel_bit) << cnt);
                cnt         <= cnt + CNT_W'(1);
                if (cnt == CNT_W'(SLAVE_SEL_W - 1)) begin
                    state       <= OCCUPIED;
                    slave_valid <= 1'b1;
`ifdef ARB_TIMEOUT_EN
                    hold        <= '0;
`endif
                end
            end else begin
`ifdef ARB_TIMEOUT_EN
                hold <= hold + HOLD_W'(1);
`endif
            end
        end
    end
endmodule

// File: doc/bus_arbiter_rr.md
Name: bus_arbiter_rr

Overview:
Parametrised N-master bus arbiter that generalises the existing two-master, fixed-priority arbiter. It sits between the masters and the master/slave select muxes of the system bus. It grants the bus to one requesting master using round-robin priority, then captures that master's serial slave address into slave_grant. It drives the one-hot master grants, the encoded bus_grant for the master mux, and the busy/slave_valid status.

Parameters:
NUM_MASTERS, 4, number of requesting masters (2..8).
SLAVE_SEL_W, 2, slave address width in bits, shifted in serially LSB first (1..4).
MASTER_ID_W, $clog2(NUM_MASTERS+1), width of the encoded bus_grant (0 = no owner).
TIMEOUT_CYCLES, 256, maximum OCCUPIED duration; used only with ARB_TIMEOUT_EN.

Ports:
clk  input  1  system clock; all logic on its rising edge.
reset  input  1  system reset; synchronous, active-high.
m_request  input  NUM_MASTERS  per-master request; held high for the whole transaction.
m_slave_select  input  NUM_MASTERS  per-master serial slave-address bit, valid after grant.
m_grant  output  NUM_MASTERS  one-hot grant to the owning master.
bus_grant  output  MASTER_ID_W  owner index + 1 to the master select mux; 0 when idle.
slave_grant  output  SLAVE_SEL_W  captured slave address to the slave select mux.
slave_valid  output  1  high while slave_grant is complete and the bus is OCCUPIED.
busy  output  1  high while the bus is owned (ADDR or OCCUPIED).
timeout_err  output  1  one-cycle pulse on forced release; tied 0 without ARB_TIMEOUT_EN.

Behaviour:
- Reset (synchronous, active-high, wins over everything): state=IDLE.
  - All outputs are 0: m_grant, bus_grant, slave_grant, slave_valid, busy, timeout_err.
  - Round-robin pointer rr_last=NUM_MASTERS-1, so master 0 wins first. Bit counter is 0.
- States: IDLE, ADDR, OCCUPIED.
- IDLE:
  - If any m_request bit is high, select the first requester searching from rr_last+1 upward with wrap-around.
  - At the next edge: set m_grant one-hot, bus_grant=idx+1, busy=1, rr_last=idx, cnt=0, slave_grant=0, state=ADDR.
  - If no request is high, stay in IDLE; all outputs stay 0 except slave_grant, which holds its last value.
- ADDR:
  - On each edge, slave_grant[cnt] <= m_slave_select[owner] and cnt increments.
  - Bit k is sampled on the (k+1)th edge after the grant edge.
  - On the edge that captures bit SLAVE_SEL_W-1: state=OCCUPIED, slave_valid=1.
  - Address latency is SLAVE_SEL_W cycles after the grant.
- OCCUPIED:
  - Hold grant, bus_grant and slave_grant stable while m_request[owner]=1.
- Release: if m_request[owner]=0 in ADDR or OCCUPIED, the next edge moves to IDLE.
  - That edge clears m_grant, bus_grant, busy, slave_valid and cnt.
  - A partially captured address is discarded: slave_valid is never set for it.
- Turnaround: arbitration happens only in IDLE, so there is at least one idle cycle between owners.
  - Requests from non-owners are ignored while busy.
- Fairness: with all masters requesting continuously, grants rotate 0,1,2,...,N-1,0.
  - A requesting master waits at most N-1 tenures.
- Requests dropping in IDLE before the grant edge are simply not considered; there is no latching.
- m_slave_select bits of non-owners are ignored.
- Width rule: cnt is $clog2(SLAVE_SEL_W+1) bits and never exceeds SLAVE_SEL_W.
- Reset mid-transaction: the next edge returns to IDLE with all reset values, including rr_last.

Optional Feature:
Macro: ARB_TIMEOUT_EN.
- Defined:
  - A hold counter clears on entry to OCCUPIED and increments each OCCUPIED cycle.
  - When it reaches TIMEOUT_CYCLES-1 with the request still high, the next edge forces release: state=IDLE, grants cleared, timeout_err=1 for exactly that one cycle.
  - rr_last still points to the timed-out master, so it gets lowest priority next.
- Undefined: no counter is present, timeout_err is constant 0, and ownership is unbounded.

Test Plan:
1. Reset, then m_request=4'b0001 held, with m_slave_select[0] driving 1 then 0.
   -> m_grant=0001 and bus_grant=1 one edge after the request; busy=1.
   -> slave_grant=2'b01 and slave_valid=1 two edges after the grant.
2. m_request=4'b1111 held; each owner drops its request 4 cycles after its slave_valid and then re-requests.
   -> bus_grant sequence is 1,2,3,4,1, with exactly one IDLE cycle between tenures.
3. Master 2 owns the bus in OCCUPIED while master 0 raises its request.
   -> No preemption: bus_grant stays 3 until master 2 drops, then one IDLE cycle, then bus_grant=1.
4. Owner drops its request after capturing 1 of 2 address bits.
   -> The next edge gives IDLE and busy=0; slave_valid is never asserted for this tenure.
5. Reset asserted during OCCUPIED with bus_grant=3.
   -> The next edge has all outputs 0. With all masters then requesting, master 0 is granted first.
6. With ARB_TIMEOUT_EN and TIMEOUT_CYCLES=8, the owner holds its request indefinitely.
   -> After 8 OCCUPIED cycles the grant is cleared and timeout_err pulses high for 1 cycle.
   -> The other requester is granted next.
